// File: rtl/binary_sub_8_serial_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encoding and counter sizing live here.
package binary_sub_8_serial_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/binary_sub_8_serial_if.sv
// Start/busy/done bundle between requester and
// the bit-serial subtractor.
interface binary_sub_8_serial_if
  import binary_sub_8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             en;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output en, start, A, B,
    input  D, borrow, busy, done
  );

  modport slave (
    input  en, start, A, B,
    output D, borrow, busy, done
  );

endinterface

// File: rtl/binary_sub_8_serial_fa_bit.sv
// One-bit full adder, shared with the
// parallel adders of the datapath.
module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/binary_sub_8_serial.sv
// Bit-serial subtractor D = A - B, LSB first,
// built as A + ~B + 1 through a single full adder.
module binary_sub_8_serial
  import binary_sub_8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  binary_sub_8_serial_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             s, cout;

  fa_bit u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (s),
    .cout_o (cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    done_d   = done_q;
    if (bus.en) begin
      done_d = 1'b0;
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (bus.start) begin
            a_sh_d  = bus.A;
            b_sh_d  = ~bus.B;
            carry_d = 1'b1;
            cnt_d   = '0;
            r_sh_d  = '0;
            state_d = ST_RUN;
          end
        end
        (state_q == ST_RUN): begin
          carry_d = cout;
          r_sh_d  = {s, r_sh_q[WIDTH-1:1]};
          a_sh_d  = a_sh_q >> 1;
          b_sh_d  = b_sh_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          // carry out of the MSB is the inverted borrow
          if (cnt_q == CW'(WIDTH-1)) begin
            d_d      = {s, r_sh_q[WIDTH-1:1]};
            borrow_d = ~cout;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign bus.D      = d_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_binary_sub_8_serial.sv
// Directed and random checks of the serial
// subtractor against plain (A-B) mod 256.
module tb_binary_sub_8_serial;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  binary_sub_8_serial_if #(.WIDTH(8)) bus ();

  binary_sub_8_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a,
                    input logic [7:0] b,
                    input bit tog,
                    input int inj);
    logic [7:0] d_prev;
    int         ne;
    bit         got;
    d_prev = bus.D;
    @(negedge clk);
    bus.en = 1'b1;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
    chk("busy_on", 32'(bus.busy), 1);
    chk("done_clr", 32'(bus.done), 0);
    chk("d_hold0", 32'(bus.D), 32'(d_prev));
    ne = 0;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (tog) bus.en = ~bus.en;
      else bus.en = 1'b1;
      if (c == inj) begin
        bus.start = 1'b1;
        bus.A = 8'd1;
        bus.B = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.en) ne++;
      if (bus.done) begin
        got = 1'b1;
      end else begin
        chk("d_hold", 32'(bus.D), 32'(d_prev));
        chk("busy_run", 32'(bus.busy), 1);
      end
    end
    bus.start = 1'b0;
    chk("timeout", 32'(got), 1);
    chk("latency", 32'(ne), 8);
    chk("D", 32'(bus.D), 32'(8'(a - b)));
    chk("borrow", 32'(bus.borrow), 32'(a < b));
    chk("busy_off", 32'(bus.busy), 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("rst_D", 32'(bus.D), 0);
    chk("rst_borrow", 32'(bus.borrow), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'd200, 8'd55, 1'b0, -1);
    op(8'd55, 8'd200, 1'b0, -1);
    op(8'd0, 8'd1, 1'b0, -1);
    op(8'd0, 8'd0, 1'b0, -1);

    op(8'hA5, 8'h5A, 1'b1, -1);
    // done stretches across an en=0 edge
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    chk("done_stretch", 32'(bus.done), 1);
    chk("D_stretch", 32'(bus.D), 32'h4B);

    op(8'd100, 8'd30, 1'b0, 3);
    op(8'd17, 8'd99, 1'b0, -1);

    @(negedge clk);
    bus.en = 1'b1;
    bus.start = 1'b1;
    bus.A = 8'd250;
    bus.B = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_D", 32'(bus.D), 0);
    chk("arst_borrow", 32'(bus.borrow), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_rst", 32'(bus.done), 0);
    end
    op(8'd9, 8'd4, 1'b0, -1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op(ra, rb, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
